// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter
//   Two-requester arbiter/sequencer in front of the 32x8 register file.
//   One operation is granted at a time. The granted operation drives the
//   register-file read1/read2/write ports for one clock per issue phase.
//   Read data comes back to the winner as a one-cycle response pulse.
//
// States
//   IDLE    | waiting for a request; req_ready is asserted to the winner
//   ISSUE_R | reads enabled (the write too, unless it would clobber a read)
//   ISSUE_W | deferred write of a read-after-write hazard, or a write-only op
//   RESP    | one-cycle rsp_valid pulse to the owner with the captured data
//
// Ports
//   clk, reset                      clock, async active-high reset
//   req_valid_i / req_ready_i       request handshake per requester (i=0,1)
//   req_ops_i                       {read1, read2, write} enables
//   req_rs1_i, req_rs2_i, req_rd_i  read-1, read-2 and write addresses
//   req_wdata_i                     write data
//   rsp_valid_i                     one-cycle response pulse per requester
//   rsp_out1, rsp_out2              shared response data
//   rf_read1, rf_read2, rf_write    register-file addresses (registered)
//   rf_write_data                   register-file write data (registered)
//   rf_input_valid                  register-file port enables (registered)
//   rf_out1, rf_out2                register-file read data
//   rf_output_valid                 register-file completion flag (monitored)
//
// Configuration
//   REG_FILE_ARB_FIXED_PRIO_EN : requester 0 always wins a tie. When the
//   macro is undefined, ties are broken round-robin.

module reg_file_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic [2:0]        req_ops_0,
  input  logic [2:0]        req_ops_1,
  input  logic [ADDR_W-1:0] req_rs1_0,
  input  logic [ADDR_W-1:0] req_rs1_1,
  input  logic [ADDR_W-1:0] req_rs2_0,
  input  logic [ADDR_W-1:0] req_rs2_1,
  input  logic [ADDR_W-1:0] req_rd_0,
  input  logic [ADDR_W-1:0] req_rd_1,
  input  logic [DATA_W-1:0] req_wdata_0,
  input  logic [DATA_W-1:0] req_wdata_1,
  output logic              rsp_valid_0,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_out1,
  output logic [DATA_W-1:0] rsp_out2,
  output logic [ADDR_W-1:0] rf_read1,
  output logic [ADDR_W-1:0] rf_read2,
  output logic [ADDR_W-1:0] rf_write,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [2:0]        rf_input_valid,
  input  logic [DATA_W-1:0] rf_out1,
  input  logic [DATA_W-1:0] rf_out2,
  input  logic              rf_output_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE_R, ISSUE_W, RESP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          ops_q, ops_d;
  logic [ADDR_W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   out1_q, out1_d, out2_q, out2_d;
  logic                owner_q, owner_d;
  logic                hazard_q, hazard_d;
  logic [2:0]          rf_en_q, rf_en_d;
  logic [1:0]          rsp_q, rsp_d;

  logic                win;
  logic                grant;
  logic [2:0]          in_ops;
  logic [ADDR_W-1:0]   in_rs1, in_rs2, in_rd;
  logic [DATA_W-1:0]   in_wdata;
  logic                in_hazard;

`ifdef REG_FILE_ARB_FIXED_PRIO_EN
  always_comb begin
    win = req_valid_0 ? 1'b0 : 1'b1;
  end
`else
  // last_q holds the most recently granted requester; on a tie the other one wins.
  logic last_q, last_d;

  always_comb begin
    if (req_valid_0 && req_valid_1) begin
      win = ~last_q;
    end else begin
      win = req_valid_0 ? 1'b0 : 1'b1;
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant) begin
      last_d = win;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Gated by reset so that no requester sees a handshake while reset is held.
  assign grant       = (state_q == IDLE) && (req_valid_0 || req_valid_1) && !reset;
  assign req_ready_0 = grant && !win;
  assign req_ready_1 = grant && win;

  assign in_ops   = win ? req_ops_1   : req_ops_0;
  assign in_rs1   = win ? req_rs1_1   : req_rs1_0;
  assign in_rs2   = win ? req_rs2_1   : req_rs2_0;
  assign in_rd    = win ? req_rd_1    : req_rd_0;
  assign in_wdata = win ? req_wdata_1 : req_wdata_0;

  // A write to a register that the same op also reads is deferred to ISSUE_W,
  // so that the read returns the value from before the write.
  assign in_hazard = in_ops[0] && ((in_ops[2] && (in_rs1 == in_rd)) ||
                                   (in_ops[1] && (in_rs2 == in_rd)));

  always_comb begin
    state_d  = state_q;
    ops_d    = ops_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    wdata_d  = wdata_q;
    owner_d  = owner_q;
    hazard_d = hazard_q;
    out1_d   = out1_q;
    out2_d   = out2_q;

    case (state_q)
      IDLE: begin
        if (grant) begin
          ops_d    = in_ops;
          rs1_d    = in_rs1;
          rs2_d    = in_rs2;
          rd_d     = in_rd;
          wdata_d  = in_wdata;
          owner_d  = win;
          hazard_d = in_hazard;
          out1_d   = '0;
          out2_d   = '0;
          if (in_ops == 3'b000) begin
            state_d = RESP;
          end else if (in_ops == 3'b001) begin
            state_d = ISSUE_W;
          end else begin
            state_d = ISSUE_R;
          end
        end
      end
      ISSUE_R: begin
        out1_d  = ops_q[2] ? rf_out1 : '0;
        out2_d  = ops_q[1] ? rf_out2 : '0;
        state_d = hazard_q ? ISSUE_W : RESP;
      end
      ISSUE_W: begin
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Enables and the response pulse are computed from the next state, so
  // that they come straight from flops during the state they belong to.
  always_comb begin
    rf_en_d = 3'b000;
    case (state_d)
      ISSUE_R: rf_en_d = {ops_d[2], ops_d[1], ops_d[0] && !hazard_d};
      ISSUE_W: rf_en_d = 3'b001;
      default: rf_en_d = 3'b000;
    endcase
  end

  always_comb begin
    rsp_d = 2'b00;
    if (state_d == RESP) begin
      rsp_d = owner_d ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ops_q    <= 3'b000;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      wdata_q  <= '0;
      owner_q  <= 1'b0;
      hazard_q <= 1'b0;
      out1_q   <= '0;
      out2_q   <= '0;
      rf_en_q  <= 3'b000;
      rsp_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      ops_q    <= ops_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
      owner_q  <= owner_d;
      hazard_q <= hazard_d;
      out1_q   <= out1_d;
      out2_q   <= out2_d;
      rf_en_q  <= rf_en_d;
      rsp_q    <= rsp_d;
    end
  end

  assign rf_read1       = rs1_q;
  assign rf_read2       = rs2_q;
  assign rf_write       = rd_q;
  assign rf_write_data  = wdata_q;
  assign rf_input_valid = rf_en_q;
  assign rsp_valid_0    = rsp_q[0];
  assign rsp_valid_1    = rsp_q[1];
  assign rsp_out1       = out1_q;
  assign rsp_out2       = out2_q;

  // The register file should report completion by the end of any enabled issue
  // cycle. The sequencer does not wait for it.
  assert property (@(posedge clk) disable iff (reset)
                   (rf_en_q != 3'b000) |-> rf_output_valid);

endmodule

// File: tb/tb_reg_file_arbiter.sv
module tb_reg_file_arbiter;

`ifdef REG_FILE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [2:0] req_ops_0, req_ops_1;
  logic [4:0] req_rs1_0, req_rs1_1, req_rs2_0, req_rs2_1, req_rd_0, req_rd_1;
  logic [7:0] req_wdata_0, req_wdata_1;
  logic       rsp_valid_0, rsp_valid_1;
  logic [7:0] rsp_out1, rsp_out2;
  logic [4:0] rf_read1, rf_read2, rf_write;
  logic [7:0] rf_write_data, rf_out1, rf_out2;
  logic [2:0] rf_input_valid;
  logic       rf_output_valid;

  always #5 clk = ~clk;

  reg_file_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_ops_0(req_ops_0), .req_ops_1(req_ops_1),
    .req_rs1_0(req_rs1_0), .req_rs1_1(req_rs1_1),
    .req_rs2_0(req_rs2_0), .req_rs2_1(req_rs2_1),
    .req_rd_0(req_rd_0), .req_rd_1(req_rd_1),
    .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_out1(rsp_out1), .rsp_out2(rsp_out2),
    .rf_read1(rf_read1), .rf_read2(rf_read2), .rf_write(rf_write),
    .rf_write_data(rf_write_data), .rf_input_valid(rf_input_valid),
    .rf_out1(rf_out1), .rf_out2(rf_out2), .rf_output_valid(rf_output_valid)
  );

  // Register file model: writes on negedge, combinational reads.
  logic [7:0] mem [32] = '{default: 8'h00};
  always @(negedge clk) begin
    if (rf_input_valid[0]) mem[rf_write] <= rf_write_data;
  end
  assign rf_out1         = mem[rf_read1];
  assign rf_out2         = mem[rf_read2];
  assign rf_output_valid = |rf_input_valid;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         owner;
    logic [7:0] o1, o2;
    int         lat;
    logic [5:0] en;
    int         acc;
  } exp_t;

  typedef struct {
    int         who;
    logic [2:0] ops;
    logic [4:0] rs1, rs2, rd;
    logic [7:0] wd, o1, o2;
    int         lat;
    logic [5:0] en;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[15];
  logic [5:0] en_log = '0;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at every negedge: logs enables and scores responses.
  task automatic sample();
    exp_t e;
    if (rf_input_valid != 3'b000) en_log = {en_log[2:0], rf_input_valid};
    if (rsp_valid_0 || rsp_valid_1) begin
      chk("rsp_onehot", {31'd0, rsp_valid_0 && rsp_valid_1}, 0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b%b, required none (cycle %0d)",
                 rsp_valid_1, rsp_valid_0, cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_owner", {31'd0, rsp_valid_1}, e.owner);
        chk("rsp_out1", {24'd0, rsp_out1}, {24'd0, e.o1});
        chk("rsp_out2", {24'd0, rsp_out2}, {24'd0, e.o2});
        chk("rsp_latency", cyc - e.acc + 1, e.lat);
        chk("rf_enable_seq", {26'd0, en_log}, {26'd0, e.en});
      end
      en_log = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    sample();
  endtask

  task automatic set_req(input int who, input logic v, input logic [2:0] ops,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [7:0] wd);
    if (who == 0) begin
      req_valid_0 = v; req_ops_0 = ops; req_rs1_0 = rs1;
      req_rs2_0 = rs2; req_rd_0 = rd; req_wdata_0 = wd;
    end else begin
      req_valid_1 = v; req_ops_1 = ops; req_rs1_1 = rs1;
      req_rs2_1 = rs2; req_rd_1 = rd; req_wdata_1 = wd;
    end
  endtask

  task automatic send(input vec_t v, input bit do_push);
    bit   got = 1'b0;
    exp_t e;
    set_req(v.who, 1'b1, v.ops, v.rs1, v.rs2, v.rd, v.wd);
    #1;
    for (int k = 0; k < 20 && !got; k++) begin
      if ((v.who == 0) ? req_ready_0 : req_ready_1) begin
        chk("loser_not_ready", {31'd0, (v.who == 0) ? req_ready_1 : req_ready_0}, 0);
        e = '{v.who, v.o1, v.o2, v.lat, v.en, cyc + 1};
        if (do_push) sb.push_back(e);
        got = 1'b1;
      end
      step();
    end
    set_req(v.who, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 8'd0);
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: requester %0d never got ready, required ready", v.who);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && sb.size() != 0; k++) step();
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d responses missing, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Both requesters hold valid with a read of rs1; grants are scored against
  // the arbitration model, which starts from the reset pointer.
  task automatic tie(input int n, input logic [4:0] a0, input logic [7:0] d0,
                     input logic [4:0] a1, input logic [7:0] d1);
    int   grants = 0;
    int   prev_acc = 0;
    int   owner;
    int   exp_owner;
    exp_t e;
    set_req(0, 1'b1, 3'b100, a0, 5'd0, 5'd0, 8'd0);
    set_req(1, 1'b1, 3'b100, a1, 5'd0, 5'd0, 8'd0);
    #1;
    for (int k = 0; k < 40 && grants < n; k++) begin
      if (req_ready_0 || req_ready_1) begin
        owner = req_ready_1 ? 1 : 0;
        exp_owner = FIXED ? 0 : (grants % 2);
        chk("tie_single_ready", {31'd0, req_ready_0 && req_ready_1}, 0);
        chk("tie_grant", owner, exp_owner);
        if (grants > 0) chk("tie_spacing", cyc + 1 - prev_acc, 3);
        prev_acc = cyc + 1;
        e = '{owner, (owner == 1) ? d1 : d0, 8'h00, 2, 6'o04, cyc + 1};
        sb.push_back(e);
        grants++;
      end
      step();
    end
    set_req(0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 8'd0);
    set_req(1, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 8'd0);
    if (grants < n) begin
      tests++;
      fails++;
      $display("FAIL tie_timeout: got %0d grants, required %0d", grants, n);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready0"}, {31'd0, req_ready_0}, 0);
    chk({tag, "_ready1"}, {31'd0, req_ready_1}, 0);
    chk({tag, "_rf_en"}, {29'd0, rf_input_valid}, 0);
    chk({tag, "_rf_addrs"}, {17'd0, rf_read1, rf_read2, rf_write}, 0);
    chk({tag, "_rf_wdata"}, {24'd0, rf_write_data}, 0);
    chk({tag, "_rsp_valid"}, {30'd0, rsp_valid_1, rsp_valid_0}, 0);
    chk({tag, "_rsp_out"}, {16'd0, rsp_out1, rsp_out2}, 0);
  endtask

  initial begin
    //           who ops     rs1 rs2 rd  wd     o1     o2     lat en
    vecs[0]  = '{0, 3'b001, 0,  0,  5,  8'hA5, 8'h00, 8'h00, 2, 6'o01};
    vecs[1]  = '{0, 3'b100, 5,  0,  0,  8'h00, 8'hA5, 8'h00, 2, 6'o04};
    vecs[2]  = '{1, 3'b001, 0,  0,  3,  8'h11, 8'h00, 8'h00, 2, 6'o01};
    vecs[3]  = '{0, 3'b101, 3,  0,  3,  8'h22, 8'h11, 8'h00, 3, 6'o41};
    vecs[4]  = '{1, 3'b100, 3,  0,  0,  8'h00, 8'h22, 8'h00, 2, 6'o04};
    vecs[5]  = '{0, 3'b001, 0,  0,  1,  8'h0F, 8'h00, 8'h00, 2, 6'o01};
    vecs[6]  = '{1, 3'b001, 0,  0,  2,  8'hF0, 8'h00, 8'h00, 2, 6'o01};
    vecs[7]  = '{0, 3'b110, 1,  2,  0,  8'h00, 8'h0F, 8'hF0, 2, 6'o06};
    vecs[8]  = '{1, 3'b000, 1,  2,  4,  8'h99, 8'h00, 8'h00, 1, 6'o00};
    vecs[9]  = '{1, 3'b011, 0,  5,  6,  8'h3C, 8'h00, 8'hA5, 2, 6'o03};
    vecs[10] = '{0, 3'b010, 0,  6,  0,  8'h00, 8'h00, 8'h3C, 2, 6'o02};
    vecs[11] = '{0, 3'b111, 6,  5,  5,  8'h5A, 8'h3C, 8'hA5, 3, 6'o61};
    vecs[12] = '{1, 3'b110, 5,  3,  0,  8'h00, 8'h5A, 8'h22, 2, 6'o06};
    vecs[13] = '{1, 3'b011, 0,  2,  2,  8'hE1, 8'h00, 8'hF0, 3, 6'o21};
    vecs[14] = '{0, 3'b010, 0,  2,  0,  8'h00, 8'h00, 8'hE1, 2, 6'o02};

    // Reset with both requesters valid: nothing may be accepted.
    reset = 1'b1;
    set_req(0, 1'b1, 3'b100, 5'd1, 5'd2, 5'd3, 8'h44);
    set_req(1, 1'b1, 3'b100, 5'd4, 5'd5, 5'd6, 8'h55);
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    set_req(0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 8'd0);
    set_req(1, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 8'd0);
    reset = 1'b0;
    step();
    chk("idle_no_valid_ready", {30'd0, req_ready_1, req_ready_0}, 0);

    for (int i = 0; i < 15; i++) begin
      send(vecs[i], 1'b1);
    end
    drain();

    // Reset restores the pointer, so requester 0 wins the first tie.
    reset = 1'b1;
    step();
    reset = 1'b0;
    en_log = '0;
    step();
    tie(4, 5'd1, 8'h0F, 5'd5, 8'h5A);
    drain();

    // Reset in the middle of a write-only op: no response, state cleared.
    send('{1, 3'b001, 5'd0, 5'd0, 5'd7, 8'h77, 8'h00, 8'h00, 2, 6'o01}, 1'b0);
    chk("mid_issue_w_en", {29'd0, rf_input_valid}, 3'b001);
    reset = 1'b1;
    set_req(0, 1'b1, 3'b100, 5'd9, 5'd9, 5'd9, 8'h66);
    set_req(1, 1'b1, 3'b100, 5'd9, 5'd9, 5'd9, 8'h66);
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset_outputs("midreset_hold");
    set_req(0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 8'd0);
    set_req(1, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 8'd0);
    reset = 1'b0;
    en_log = '0;
    repeat (3) step();
    tie(1, 5'd3, 8'h22, 5'd1, 8'h0F);
    drain();
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_arbiter.md
# reg_file_arbiter

Two-requester arbiter and sequencer for the 32x8 register file. It accepts read/write operations from two independent masters over valid/ready handshakes and grants one operation at a time, round-robin. It drives the register file's read1/read2/write ports for exactly one clock per issue phase and returns read data to the winning master as a one-cycle response pulse. It sits between the datapath masters (e.g. ALU sequencer, debug loader) and the register file.

## Interface
- ADDR_W, 5, register address width (32 entries)
- DATA_W, 8, register data width
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-high reset
- req_valid_0 / req_valid_1  input  1  requester i presents an operation
- req_ready_0 / req_ready_1  output  1  arbiter accepts requester i's operation this cycle
- req_ops_0 / req_ops_1  input  3  bit2 = read port 1, bit1 = read port 2, bit0 = write
- req_rs1_0 / req_rs1_1  input  ADDR_W  read port 1 address
- req_rs2_0 / req_rs2_1  input  ADDR_W  read port 2 address
- req_rd_0 / req_rd_1  input  ADDR_W  write address
- req_wdata_0 / req_wdata_1  input  DATA_W  write data
- rsp_valid_0 / rsp_valid_1  output  1  one-cycle response pulse to requester i
- rsp_out1, rsp_out2  output  DATA_W  shared response data, valid only when a rsp_valid_i is high
- rf_read1, rf_read2, rf_write  output  ADDR_W  register file addresses
- rf_write_data  output  DATA_W  register file write data
- rf_input_valid  output  3  register file port enables (same bit order as req_ops)
- rf_out1, rf_out2  input  DATA_W  register file read data
- rf_output_valid  input  1  register file completion flag

## Operation
- States: IDLE, ISSUE_R, ISSUE_W, RESP.
- IDLE: if any req_valid_i, pick winner; assert req_ready of winner only (combinational in IDLE); on posedge with valid&&ready, latch ops/addresses/data and owner.
- Next state from IDLE: ops==000 -> RESP; hazard (ops[0] and a read bit set whose address equals rd) -> ISSUE_R; ops has only write -> ISSUE_W; otherwise ISSUE_R.
- ISSUE_R: rf_input_valid = {ops[2], ops[1], ops[0] && !hazard}; on exiting posedge capture rf_out1 if ops[2] else 0, rf_out2 if ops[1] else 0. Next: hazard -> ISSUE_W, else RESP.
- ISSUE_W: rf_input_valid = 001; next RESP. Hazard ordering guarantees reads return the pre-write value.
- RESP: rsp_valid of owner = 1 for exactly one cycle with captured data; next IDLE. No backpressure on responses.
- Round-robin: last-grant pointer flips to the granted requester; when both valid, the non-last requester wins. Pointer resets to 1 (requester 0 wins first tie).
- rf_* address/data outputs hold the latched values; rf_input_valid = 000 outside ISSUE states.
- rf_output_valid is monitored only: it must be high at posedge exiting an ISSUE state with nonzero enables; otherwise the arbiter still proceeds (verification asserts it).

## Timing
- All outputs except req_ready are registered; rf_* outputs are stable from posedge for a full cycle so the register file's negedge sample sees settled values.
- Accept at posedge T -> ISSUE_R during T..T+1 -> rsp_valid during T+1..T+2 (latency 2, throughput 1 op / 3 cycles); hazard case adds one cycle (latency 3); ops==000 latency 1.
- req_ready is 0 in every state except IDLE; back-to-back requests from one master are spaced by at least 3 cycles.
- Reset (any time, including mid-ISSUE): state IDLE, rf_input_valid=000, rf_* addresses/data=0, rsp_valid_i=0, rsp_out1/2=0, req_ready_i=0 while reset asserted, pointer=1; in-flight operation dropped with no response. A register-file write may already have been sampled if reset arrives after the negedge.

## Configuration
- REG_FILE_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins when both valid; pointer unused.
- Undefined (default): round-robin as above.

## Test plan
- Reset then req_valid_0 with ops=001, rd=5, wdata=0xA5 -> rf_input_valid=001 one cycle, rsp_valid_0 pulse; then ops=100, rs1=5 -> rsp_out1=0xA5.
- Both valid every cycle, ops=100 -> grants alternate 0,1,0,1; with REG_FILE_ARB_FIXED_PRIO_EN grants 0,0,0,0.
- Hazard: reg 3 = 0x11, op ops=101, rs1=3, rd=3, wdata=0x22 -> ISSUE_R then ISSUE_W, rsp_out1=0x11; subsequent read of 3 returns 0x22.
- Dual read ops=110, rs1=1 (0x0F), rs2=2 (0xF0) -> rsp_out1=0x0F, rsp_out2=0xF0, latency 2.
- ops=000 -> rsp_valid one cycle after accept, rsp_out1=rsp_out2=0, rf_input_valid never nonzero.
- Assert reset during ISSUE_W -> all outputs reset values, no rsp_valid, next request served normally with requester 0 winning a tie.
